// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM stage: branch-type codes and default widths.
// Also used by the branch condition unit so early-branch logic sees the same encodings.
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLTZ = 3'd3,
        BR_BGEZ = 3'd4
    } br_type_e;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Combinational branch condition: decides taken from a branch kind and the ALU flags.
// Codes outside the defined set never take.
module branch_cond
    import ex_mem_stage_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       zero,
    input  logic       neg,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLTZ: taken = neg;
            BR_BGEZ: taken = ~neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution in MEM and saturating branch statistics.
// A taken branch redirects the PC once and replaces the wrong-path EX instruction with a bubble.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic              alu_zout,
    input  logic              alu_nout,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    input  logic [2:0]        ex_br_type,
    input  logic [DATA_W-1:0] ex_br_target,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_wreg,
    output logic              mem_regwrite,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_memtoreg,
    output logic              mem_zero,
    output logic              mem_neg,
    output logic              pc_src,
    output logic [DATA_W-1:0] br_target,
    output logic              redirect_flush,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_wreg;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_memtoreg;
    logic              r_zero;
    logic              r_neg;
    logic [2:0]        r_br_type;
    logic [DATA_W-1:0] r_br_target;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic w_taken;
    logic w_pc_src;
    logic w_count_br;

    branch_cond u_branch_cond (
        .br_type (r_br_type),
        .zero    (r_zero),
        .neg     (r_neg),
        .taken   (w_taken)
    );

    // Stall masks the redirect so a held branch fires only once it can leave MEM.
    assign w_pc_src   = r_valid & w_taken & ~stall;
    assign w_count_br = r_valid & (r_br_type != BR_NONE) & ~stall;

    always_ff @(posedge clk) begin
        if (rst || (!stall && (flush || w_pc_src))) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_wreg       <= '0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_zero       <= 1'b0;
            r_neg        <= 1'b0;
            r_br_type    <= BR_NONE;
            r_br_target  <= '0;
        end else if (!stall) begin
            // Data fields load even for an invalid slot; only control is squashed.
            r_valid      <= ex_valid;
            r_alu_result <= alu_sum;
            r_store_data <= ex_store_data;
            r_wreg       <= ex_wreg;
            r_regwrite   <= ex_regwrite & ex_valid;
            r_memread    <= ex_memread & ex_valid;
            r_memwrite   <= ex_memwrite & ex_valid;
            r_memtoreg   <= ex_memtoreg & ex_valid;
            r_zero       <= alu_zout;
            r_neg        <= alu_nout;
            r_br_type    <= ex_valid ? ex_br_type : BR_NONE;
            r_br_target  <= ex_br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (w_count_br) begin
            if (r_br_cnt != '1) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_valid      = r_valid;
    assign mem_alu_result = r_alu_result;
    assign mem_store_data = r_store_data;
    assign mem_wreg       = r_wreg;
    assign mem_regwrite   = r_regwrite & r_valid;
    assign mem_memread    = r_memread & r_valid;
    assign mem_memwrite   = r_memwrite & r_valid;
    assign mem_memtoreg   = r_memtoreg & r_valid;
    assign mem_zero       = r_zero;
    assign mem_neg        = r_neg;
    assign pc_src         = w_pc_src;
    assign redirect_flush = w_pc_src;
    assign br_target      = r_br_target;
    assign br_cnt         = r_br_cnt;
    assign taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a table of single instructions through a scoreboard queue,
// then hand sequences for stall, flush, reset and counter saturation (second instance, CNT_W=2).
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    localparam int EW = 110;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid;
    logic [31:0] alu_sum, ex_store_data, ex_br_target;
    logic        alu_zout, alu_nout;
    logic [4:0]  ex_wreg;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [2:0]  ex_br_type;

    logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
    logic        mem_zero, mem_neg, pc_src, redirect_flush;
    logic [31:0] mem_alu_result, mem_store_data, br_target;
    logic [4:0]  mem_wreg;
    logic [15:0] br_cnt, taken_cnt;

    logic        s_valid, s_regwrite, s_memread, s_memwrite, s_memtoreg;
    logic        s_zero, s_neg, s_pc_src, s_redirect_flush;
    logic [31:0] s_alu_result, s_store_data, s_br_target;
    logic [4:0]  s_wreg;
    logic [1:0]  s_br_cnt, s_taken_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_nout(alu_nout),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_br_type(ex_br_type), .ex_br_target(ex_br_target),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg), .mem_zero(mem_zero),
        .mem_neg(mem_neg), .pc_src(pc_src), .br_target(br_target),
        .redirect_flush(redirect_flush), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    ex_mem_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_nout(alu_nout),
        .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_br_type(ex_br_type), .ex_br_target(ex_br_target),
        .mem_valid(s_valid), .mem_alu_result(s_alu_result), .mem_store_data(s_store_data),
        .mem_wreg(s_wreg), .mem_regwrite(s_regwrite), .mem_memread(s_memread),
        .mem_memwrite(s_memwrite), .mem_memtoreg(s_memtoreg), .mem_zero(s_zero),
        .mem_neg(s_neg), .pc_src(s_pc_src), .br_target(s_br_target),
        .redirect_flush(s_redirect_flush), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
    );

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic        z;
        logic        n;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic        rw, mr, mw, mt;
        logic [2:0]  bt;
        logic [31:0] tgt;
        logic        exp_pc;
        logic        is_br;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic v, logic [31:0] alu, logic z, logic n, logic [31:0] sd,
                                logic [4:0] wr, logic rw, logic mr, logic mw, logic mt,
                                logic [2:0] bt, logic [31:0] tgt, logic exp_pc, logic is_br);
        vec_t r;
        r.v = v; r.alu = alu; r.z = z; r.n = n; r.sd = sd; r.wr = wr;
        r.rw = rw; r.mr = mr; r.mw = mw; r.mt = mt; r.bt = bt; r.tgt = tgt;
        r.exp_pc = exp_pc; r.is_br = is_br;
        return r;
    endfunction

    function automatic logic [EW-1:0] pack_act();
        return {mem_valid, mem_alu_result, mem_store_data, mem_wreg, mem_regwrite, mem_memread,
                mem_memwrite, mem_memtoreg, mem_zero, mem_neg, pc_src, redirect_flush, br_target};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        ex_valid = t.v; alu_sum = t.alu; alu_zout = t.z; alu_nout = t.n;
        ex_store_data = t.sd; ex_wreg = t.wr; ex_regwrite = t.rw; ex_memread = t.mr;
        ex_memwrite = t.mw; ex_memtoreg = t.mt; ex_br_type = t.bt; ex_br_target = t.tgt;
    endtask

    task automatic drive_bubble();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BR_NONE, 0, 0, 0));
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_bubble();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_br, exp_tk;
        logic [EW-1:0] exp_v;

        vecs[0]  = mk(1, 32'h7,         0, 0, 0,            5'd9, 1, 0, 0, 0, BR_NONE, 32'h0,   0, 0);
        vecs[1]  = mk(1, 32'h0,         1, 0, 0,            5'd0, 0, 0, 0, 0, BR_BEQ,  32'h40,  1, 1);
        vecs[2]  = mk(1, 32'h12,        0, 0, 0,            5'd0, 0, 0, 0, 0, BR_BEQ,  32'h80,  0, 1);
        vecs[3]  = mk(1, 32'h12,        0, 0, 0,            5'd0, 0, 0, 0, 0, BR_BNE,  32'hc0,  1, 1);
        vecs[4]  = mk(1, 32'h0,         1, 0, 0,            5'd0, 0, 0, 0, 0, BR_BNE,  32'h100, 0, 1);
        vecs[5]  = mk(1, 32'h3,         0, 0, 0,            5'd0, 0, 0, 0, 0, BR_BLTZ, 32'h140, 0, 1);
        vecs[6]  = mk(1, 32'h8000_0000, 0, 1, 0,            5'd0, 0, 0, 0, 0, BR_BLTZ, 32'h180, 1, 1);
        vecs[7]  = mk(1, 32'h5,         0, 0, 0,            5'd0, 0, 0, 0, 0, BR_BGEZ, 32'h1c0, 1, 1);
        vecs[8]  = mk(1, 32'hffff_fff0, 0, 1, 0,            5'd0, 0, 0, 0, 0, BR_BGEZ, 32'h200, 0, 1);
        vecs[9]  = mk(1, 32'h0,         1, 1, 0,            5'd0, 0, 0, 0, 0, 3'd7,    32'h240, 0, 1);
        vecs[10] = mk(0, 32'h55,        1, 0, 32'hdead_beef, 5'd3, 0, 0, 1, 0, BR_BEQ,  32'h280, 0, 0);
        vecs[11] = mk(1, 32'h1000,      0, 0, 32'hcafe,      5'd8, 1, 1, 0, 1, BR_NONE, 32'h0,   0, 0);
        vecs[12] = mk(1, 32'h2000,      0, 0, 32'h1234_5678, 5'd0, 0, 0, 1, 0, BR_NONE, 32'h0,   0, 0);

        // Reset with random EX inputs
        rst = 1'b1; stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
        drive(mk(1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 5'($urandom_range(0, 31)), 1, 1, 1, 1, 3'($urandom_range(1, 4)), $urandom, 0, 0));
        tick();
        tick();
        chk("reset_outputs", 128'(pack_act()), 128'(0));
        chk("reset_br_cnt", 128'(br_cnt), 128'(0));
        chk("reset_taken_cnt", 128'(taken_cnt), 128'(0));
        chk("reset_sat_cnts", 128'({s_br_cnt, s_taken_cnt}), 128'(0));
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_bubble();
        tick();

        // Table: each instruction followed by a bubble so taken branches drain
        exp_br = 0;
        exp_tk = 0;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            exp_q.push_back({vecs[i].v, vecs[i].alu, vecs[i].sd, vecs[i].wr,
                             vecs[i].rw & vecs[i].v, vecs[i].mr & vecs[i].v,
                             vecs[i].mw & vecs[i].v, vecs[i].mt & vecs[i].v,
                             vecs[i].z, vecs[i].n, vecs[i].exp_pc, vecs[i].exp_pc, vecs[i].tgt});
            tick();
            exp_v = exp_q.pop_front();
            chk($sformatf("vec%0d_outputs", i), 128'(pack_act()), 128'(exp_v));
            if (vecs[i].is_br) exp_br++;
            if (vecs[i].exp_pc) exp_tk++;
            drive_bubble();
            tick();
            chk($sformatf("vec%0d_bubble_valid", i), 128'({mem_valid, pc_src}), 128'(0));
            chk($sformatf("vec%0d_br_cnt", i), 128'(br_cnt), 128'(exp_br));
            chk($sformatf("vec%0d_taken_cnt", i), 128'(taken_cnt), 128'(exp_tk));
            chk($sformatf("vec%0d_sat_cnts", i), 128'({s_br_cnt, s_taken_cnt}),
                128'({2'((exp_br > 3) ? 3 : exp_br), 2'((exp_tk > 3) ? 3 : exp_tk)}));
        end

        // Taken BNE held by a 3-cycle stall, wrong-path EX instruction behind it
        do_reset();
        drive(mk(1, 32'h5, 0, 0, 0, 5'd0, 0, 0, 0, 0, BR_BNE, 32'h100, 0, 0));
        tick();
        stall = 1'b1;
        drive(mk(1, 32'h99, 1, 0, 0, 5'd4, 1, 0, 0, 0, BR_BEQ, 32'h500, 0, 0));
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d_pc_src", c), 128'({pc_src, redirect_flush}), 128'(0));
            chk($sformatf("stall%0d_hold", c), 128'({mem_valid, mem_alu_result, br_target}),
                128'({1'b1, 32'h5, 32'h100}));
            chk($sformatf("stall%0d_br_cnt", c), 128'(br_cnt), 128'(0));
            tick();
        end
        stall = 1'b0;
        #1;
        chk("unstall_pc_src", 128'({pc_src, redirect_flush, br_target}), 128'({2'b11, 32'h100}));
        tick();
        drive_bubble();
        chk("unstall_self_flush", 128'(pack_act()), 128'(0));
        chk("unstall_cnts", 128'({br_cnt, taken_cnt}), 128'({16'd1, 16'd1}));
        tick();
        chk("unstall_no_second", 128'({pc_src, br_cnt, taken_cnt}), 128'({1'b0, 16'd1, 16'd1}));

        // Flush together with stall: stall wins, flush takes effect once stall drops
        do_reset();
        drive(mk(1, 32'h11, 0, 0, 32'h22, 5'd7, 1, 0, 0, 0, BR_NONE, 0, 0, 0));
        tick();
        flush = 1'b1; stall = 1'b1;
        drive(mk(1, 32'h33, 0, 0, 32'h44, 5'd6, 1, 0, 1, 0, BR_NONE, 0, 0, 0));
        tick();
        chk("flush_stall_hold", 128'({mem_valid, mem_alu_result, mem_wreg, mem_regwrite}),
            128'({1'b1, 32'h11, 5'd7, 1'b1}));
        stall = 1'b0;
        tick();
        chk("flush_bubble", 128'(pack_act()), 128'(0));
        flush = 1'b0;
        tick();
        chk("flush_released", 128'({mem_valid, mem_alu_result, mem_memwrite}),
            128'({1'b1, 32'h33, 1'b1}));

        // Reset while a taken branch sits in MEM
        do_reset();
        drive(mk(1, 32'h0, 1, 0, 0, 5'd0, 0, 0, 0, 0, BR_BEQ, 32'h600, 0, 0));
        tick();
        chk("rst_mid_pc_src_before", 128'(pc_src), 128'(1));
        rst = 1'b1;
        tick();
        chk("rst_mid_after", 128'({pc_src, redirect_flush, mem_valid, br_cnt, taken_cnt}), 128'(0));
        rst = 1'b0;

        // Five taken branches: wide counters reach 5, 2-bit counters stop at 3
        drive_bubble();
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(mk(1, 32'h0, 1, 0, 0, 5'd0, 0, 0, 0, 0, BR_BEQ, 32'h40, 0, 0));
            tick();
            drive_bubble();
            tick();
        end
        chk("sat_wide_cnts", 128'({br_cnt, taken_cnt}), 128'({16'd5, 16'd5}));
        chk("sat_narrow_cnts", 128'({s_br_cnt, s_taken_cnt}), 128'({2'd3, 2'd3}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
